pps_qualifier: RTL and testbench

//  Validates the synchronized PPS input (output of the adc.clk-domain level synchronizer) before it reaches
//  the receiver core's pps_in. It measures rise-to-rise spacing, requires LOCK_CNT consecutive in-window

---
 rtl/pps_qualifier.sv | 157 +++++++++++++++
 tb/tb_pps_qualifier.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pps_qualifier.sv
// PPS qualifier: measures rise-to-rise spacing, locks after consecutive
// good periods and flywheels synthetic pulses through short dropouts.
module pps_qualifier #(
  parameter int CNT_WIDTH  = 32,
  parameter int NOM_PERIOD = 100_000_000,
  parameter int TOL        = 1000,
  parameter int LOCK_CNT   = 3,
  parameter int MAX_HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pps_in,
  output logic                 pps_out,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 holdover,
  output logic                 err_pulse
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LO  = CNT_WIDTH'(NOM_PERIOD - TOL);
  localparam logic [CNT_WIDTH-1:0] HI  = CNT_WIDTH'(NOM_PERIOD + TOL);
  localparam logic [CNT_WIDTH-1:0] EXP = CNT_WIDTH'(NOM_PERIOD - 1);
  localparam logic [GW-1:0]        LOCK_N = GW'(LOCK_CNT);
  localparam logic [HW-1:0]        HOLD_N = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, HOLD} state_t;

  state_t               state, state_n;
  logic                 pps_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, meas, period_n;
  logic [GW-1:0]        good_cnt, good_cnt_n, gc_inc;
  logic [HW-1:0]        hold_cnt, hold_cnt_n;
  logic                 rise, sat, good, miss, expire;
  logic                 pps_n, pv_n, err_n, locked_n, hold_n;

  always_comb begin
    rise   = pps_in & ~pps_d;
    sat    = &cnt;
    meas   = cnt + ONE;
    // a saturated counter wraps meas, so it can never count as good
    good   = !sat && (meas >= LO) && (meas <= HI);
    miss   = (cnt == HI) && !rise;
    expire = (cnt == EXP) && !rise;
    gc_inc = good_cnt + GW'(1);

    state_n    = state;
    cnt_n      = rise ? '0 : (sat ? cnt : cnt + ONE);
    good_cnt_n = good_cnt;
    hold_cnt_n = hold_cnt;
    period_n   = period;
    pv_n       = 1'b0;
    pps_n      = 1'b0;
    err_n      = 1'b0;

    if (rise && state != IDLE) begin
      period_n = meas;
      pv_n     = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n    = ACQ;
          good_cnt_n = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          if (good) begin
            good_cnt_n = gc_inc;
            if (gc_inc == LOCK_N) begin
              state_n    = LOCKED;
              good_cnt_n = '0;
              pps_n      = 1'b1;
            end
          end else begin
            good_cnt_n = '0;
            err_n      = 1'b1;
          end
        end else if (miss) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (good) begin
            pps_n = 1'b1;
          end else begin
            state_n    = ACQ;
            good_cnt_n = '0;
            err_n      = 1'b1;
          end
        end else if (miss) begin
          state_n    = HOLD;
          pps_n      = 1'b1;
          err_n      = 1'b1;
          hold_cnt_n = HW'(1);
          cnt_n      = '0;
        end
      end
      HOLD: begin
        if (rise) begin
          state_n    = ACQ;
          good_cnt_n = '0;
        end else if (expire) begin
          cnt_n = '0;
          if (hold_cnt == HOLD_N) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            pps_n      = 1'b1;
            hold_cnt_n = hold_cnt + HW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    locked_n = (state_n == LOCKED) || (state_n == HOLD);
    hold_n   = (state_n == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pps_d        <= 1'b0;
      cnt          <= '0;
      good_cnt     <= '0;
      hold_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      pps_out      <= 1'b0;
      err_pulse    <= 1'b0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
    end else begin
      state        <= state_n;
      pps_d        <= pps_in;
      cnt          <= cnt_n;
      good_cnt     <= good_cnt_n;
      hold_cnt     <= hold_cnt_n;
      period       <= period_n;
      period_valid <= pv_n;
      pps_out      <= pps_n;
      err_pulse    <= err_n;
      locked       <= locked_n;
      holdover     <= hold_n;
    end
  end

endmodule

// File: tb/tb_pps_qualifier.sv
// Directed bench for pps_qualifier: table of rise gaps plus
// hand sequences for holdover, reset and stuck-high input.
module tb_pps_qualifier;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pps_in;
  logic         pps_out;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         holdover;
  logic         err_pulse;

  always #5 clk = ~clk;

  pps_qualifier #(
    .CNT_WIDTH (W),
    .NOM_PERIOD(100),
    .TOL       (2),
    .LOCK_CNT  (3),
    .MAX_HOLD  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pps_in      (pps_in),
    .pps_out     (pps_out),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .holdover    (holdover),
    .err_pulse   (err_pulse)
  );

  typedef struct {
    int gap;
    bit pps;
    bit pv;
    bit err;
    bit lk;
    bit ho;
    int per;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int gap_pulses;
  bit hold_hi = 1'b0;
  vec_t tbl[16];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // next rise lands n cycles after the previous one; samples after it
  task automatic pulse_gap(input int n);
    gap_pulses = 0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (pps_out || err_pulse || period_valid) gap_pulses++;
    end
    pps_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_hi) pps_in = 1'b0;
  endtask

  task automatic step_until(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pps_out || err_pulse) && n < limit);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    tbl[0]  = '{1,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{100, 0, 1, 0, 0, 0, 100};
    tbl[2]  = '{100, 0, 1, 0, 0, 0, 100};
    tbl[3]  = '{100, 1, 1, 0, 1, 0, 100};
    tbl[4]  = '{100, 1, 1, 0, 1, 0, 100};
    tbl[5]  = '{98,  1, 1, 0, 1, 0, 98};
    tbl[6]  = '{102, 1, 1, 0, 1, 0, 102};
    tbl[7]  = '{97,  0, 1, 1, 0, 0, 97};
    tbl[8]  = '{100, 0, 1, 0, 0, 0, 100};
    tbl[9]  = '{100, 0, 1, 0, 0, 0, 100};
    tbl[10] = '{100, 1, 1, 0, 1, 0, 100};
    tbl[11] = '{103, 0, 1, 1, 0, 0, 103};
    tbl[12] = '{50,  0, 1, 1, 0, 0, 50};
    tbl[13] = '{100, 0, 1, 0, 0, 0, 100};
    tbl[14] = '{100, 0, 1, 0, 0, 0, 100};
    tbl[15] = '{100, 1, 1, 0, 1, 0, 100};

    rst    = 1'b1;
    pps_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pps", int'(pps_out), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_err", int'(err_pulse), 0);
    chk("rst_lk", int'(locked), 0);
    chk("rst_ho", int'(holdover), 0);
    chk("rst_per", int'(period), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pulse_gap(tbl[i].gap);
      chk($sformatf("v%0d_gap", i), gap_pulses, 0);
      chk($sformatf("v%0d_pps", i), int'(pps_out), int'(tbl[i].pps));
      chk($sformatf("v%0d_pv", i), int'(period_valid), int'(tbl[i].pv));
      chk($sformatf("v%0d_err", i), int'(err_pulse), int'(tbl[i].err));
      chk($sformatf("v%0d_lk", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("v%0d_ho", i), int'(holdover), int'(tbl[i].ho));
      chk($sformatf("v%0d_per", i), int'(period), tbl[i].per);
    end

    // input stops: miss, one flywheel pulse, then drop out
    step_until(300, n);
    chk("hold1_dly", n, 103);
    chk("hold1_pps", int'(pps_out), 1);
    chk("hold1_err", int'(err_pulse), 1);
    chk("hold1_ho", int'(holdover), 1);
    chk("hold1_lk", int'(locked), 1);
    step_until(300, n);
    chk("hold2_dly", n, 100);
    chk("hold2_pps", int'(pps_out), 1);
    chk("hold2_err", int'(err_pulse), 0);
    chk("hold2_ho", int'(holdover), 1);
    step_until(300, n);
    chk("hold3_dly", n, 100);
    chk("hold3_pps", int'(pps_out), 0);
    chk("hold3_err", int'(err_pulse), 1);
    chk("hold3_lk", int'(locked), 0);
    chk("hold3_ho", int'(holdover), 0);

    // relock, enter holdover, then a real edge interrupts it
    pulse_gap(10);
    chk("idle_pv", int'(period_valid), 0);
    chk("idle_lk", int'(locked), 0);
    repeat (3) pulse_gap(100);
    chk("relock_pps", int'(pps_out), 1);
    chk("relock_lk", int'(locked), 1);
    step_until(300, n);
    chk("ho_dly", n, 103);
    chk("ho_flag", int'(holdover), 1);
    pulse_gap(40);
    chk("hoint_gap", gap_pulses, 0);
    chk("hoint_pps", int'(pps_out), 0);
    chk("hoint_lk", int'(locked), 0);
    chk("hoint_ho", int'(holdover), 0);
    chk("hoint_per", int'(period), 40);

    // reset in the middle of a locked second
    repeat (3) pulse_gap(100);
    chk("lock3_lk", int'(locked), 1);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_pps", int'(pps_out), 0);
    chk("mrst_lk", int'(locked), 0);
    chk("mrst_per", int'(period), 0);
    rst = 1'b0;
    pulse_gap(20);
    chk("post_pv", int'(period_valid), 0);
    chk("post_lk", int'(locked), 0);

    // second rise is good, then pps_in sticks high
    hold_hi = 1'b1;
    pulse_gap(100);
    chk("acq_pv", int'(period_valid), 1);
    chk("acq_per", int'(period), 100);
    chk("acq_lk", int'(locked), 0);
    step_until(300, n);
    chk("stuck_dly", n, 103);
    chk("stuck_err", int'(err_pulse), 1);
    chk("stuck_pps", int'(pps_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
